// File: rtl/bk_adder_pkg.sv
// Shared types for the Brent-Kung adder: operand width, PG vector type,
// result payload and skid-buffer occupancy encoding.
package bk_adder_pkg;

    localparam int BK_WIDTH = 32;
    localparam int BK_TAG_W = 4;

    typedef logic [BK_WIDTH:0] pg_vec_t;

    typedef struct packed {
        logic [BK_WIDTH-1:0] sum;
        logic                cout;
        logic [BK_TAG_W-1:0] tag;
    } bk_result_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/bk_skid_buffer.sv
// Generic 2-entry skid buffer: main register drives the outputs, the skid
// register catches one beat while the consumer stalls. in_ready is a flop.
module bk_skid_buffer
    import bk_adder_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    occ_e              state;
    occ_e              state_next;
    logic              ready_q;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              acc;
    logic              pop;
    logic              load_main;
    logic              load_skid;
    logic              main_from_skid;

    assign acc       = in_valid && ready_q;
    assign pop       = out_valid && out_ready;
    assign in_ready  = ready_q;
    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;

    // Ready is registered from the next occupancy so it never combinationally follows out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= EMPTY;
            ready_q <= 1'b1;
        end else begin
            state   <= state_next;
            ready_q <= (state_next != TWO);
        end
    end

    always_comb begin
        state_next     = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (acc) begin
                    load_main  = 1'b1;
                    state_next = ONE;
                end
            end
            ONE: begin
                if (acc && pop) begin
                    load_main = 1'b1;
                end else if (acc) begin
                    load_skid  = 1'b1;
                    state_next = TWO;
                end else if (pop) begin
                    state_next = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    main_from_skid = 1'b1;
                    state_next     = ONE;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // Payload only moves on a real transfer, so idle-cycle garbage never reaches the registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main) begin
                main_q <= in_data;
            end else if (main_from_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/bk_sum_output_stage.sv
// Final Brent-Kung stage: sum = P_(k+1) ^ G_k:0, cout = G_WIDTH:0, registered
// together with a sideband tag behind a 2-entry skid buffer.
module bk_sum_output_stage
    import bk_adder_pkg::*;
#(
    parameter int WIDTH = BK_WIDTH,
    parameter int TAG_W = BK_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   p_bits,
    input  logic [WIDTH:0]   g_prefix,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [TAG_W-1:0] out_tag
);

    localparam int PAY_W = WIDTH + 1 + TAG_W;

    logic [WIDTH-1:0] sum_c;
    logic             cout_c;
    logic [PAY_W-1:0] pay_in;
    logic [PAY_W-1:0] pay_out;
    logic             unused_p0;

    // Index 0 of the PG vectors is the carry-in position, so operand bit k pairs P(k+1) with G(k):0.
    assign sum_c     = p_bits[WIDTH:1] ^ g_prefix[WIDTH-1:0];
    assign cout_c    = g_prefix[WIDTH];
    assign unused_p0 = p_bits[0];
    assign pay_in    = {sum_c, cout_c, in_tag};

    bk_skid_buffer #(
        .DATA_W(PAY_W)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (pay_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (pay_out)
    );

    assign {sum, cout, out_tag} = pay_out;

endmodule

// File: tb/tb_bk_sum_output_stage.sv
// Scoreboard bench for bk_sum_output_stage: PG vectors are built from A/B/cin,
// expected A+B+cin results are queued on accept and compared at the output.
module tb_bk_sum_output_stage;
    import bk_adder_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    pg_vec_t          p_bits;
    pg_vec_t          g_prefix;
    logic [3:0]       in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      sum;
    logic             cout;
    logic [3:0]       out_tag;

    int               n_cmp  = 0;
    int               n_fail = 0;
    int               n_pop  = 0;
    bk_result_t       sb[$];

    bk_sum_output_stage dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .p_bits   (p_bits),
        .g_prefix (g_prefix),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .out_tag  (out_tag)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Upstream model: ripple group generates G_i:0 with carry-in at index 0
    task automatic buildPg(input logic [31:0] a, input logic [31:0] b, input logic cin);
        p_bits      = '0;
        g_prefix    = '0;
        g_prefix[0] = cin;
        for (int i = 0; i < 32; i++) begin
            p_bits[i+1]   = a[i] ^ b[i];
            g_prefix[i+1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & g_prefix[i]);
        end
    endtask

    // Drives one cycle of stimulus at negedge, then observes both handshakes for the coming edge
    task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic [3:0] tag, input logic ordy,
                                 output logic accepted);
        bk_result_t exp;
        logic [32:0] full;
        @(negedge clk);
        in_valid  = v;
        in_tag    = tag;
        out_ready = ordy;
        if (v) buildPg(a, b, cin);
        else begin
            p_bits   = 'x;
            g_prefix = 'x;
        end
        #1;
        if (out_valid) begin
            if (sb.size() == 0) begin
                checkOutput("spurious_valid", out_valid, 1'b0);
            end else begin
                checkOutput("result", {sum, cout, out_tag}, sb[0]);
                if (out_ready) begin
                    void'(sb.pop_front());
                    n_pop++;
                end
            end
        end
        accepted = v && in_ready;
        if (accepted) begin
            full     = {1'b0, a} + {1'b0, b} + {32'd0, cin};
            exp.sum  = full[31:0];
            exp.cout = full[32];
            exp.tag  = tag;
            sb.push_back(exp);
        end
    endtask

    task automatic idle(input logic ordy);
        logic acc;
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 4'd0, ordy, acc);
    endtask

    task automatic drain(input string name);
        int budget = 50;
        while (sb.size() > 0 && budget > 0) begin
            idle(1'b1);
            budget--;
        end
        checkOutput(name, sb.size(), 0);
    endtask

    initial begin
        logic        acc;
        logic        have;
        logic [31:0] a, b;
        logic        cin;
        logic [3:0]  tag;
        int          pops0;
        int          accs;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_tag    = '0;
        p_bits    = '0;
        g_prefix  = '0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_in_ready", in_ready, 1'b1);
        checkOutput("rst_sum", sum, 32'd0);
        checkOutput("rst_cout", cout, 1'b0);
        checkOutput("rst_tag", out_tag, 4'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] single add and carry chain");
        applyStimulus(1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 4'd5, 1'b1, acc);
        checkOutput("single_accept", acc, 1'b1);
        idle(1'b1);
        checkOutput("single_lat_valid", out_valid, 1'b1);
        checkOutput("single_sum", sum, 32'h0);
        checkOutput("single_cout", cout, 1'b1);
        applyStimulus(1'b1, 32'h7FFF_FFFF, 32'h0, 1'b1, 4'd6, 1'b1, acc);
        applyStimulus(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 4'd7, 1'b1, acc);
        idle(1'b1);
        checkOutput("chain2_sum", sum, 32'h0);
        checkOutput("chain2_cout", cout, 1'b1);
        drain("drain_single");

        $display("[TB] streaming");
        pops0 = n_pop;
        accs  = 0;
        for (int i = 0; i < 1000; i++) begin
            applyStimulus(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 4'(i), 1'b1, acc);
            if (acc) accs++;
        end
        idle(1'b1);
        checkOutput("stream_accepts", accs, 1000);
        checkOutput("stream_pops", n_pop - pops0, 1000);
        drain("drain_stream");

        $display("[TB] backpressure");
        applyStimulus(1'b1, 32'd10, 32'd1, 1'b0, 4'd1, 1'b0, acc);
        checkOutput("bp_acc1", acc, 1'b1);
        applyStimulus(1'b1, 32'd20, 32'd2, 1'b1, 4'd2, 1'b0, acc);
        checkOutput("bp_acc2", acc, 1'b1);
        applyStimulus(1'b1, 32'd30, 32'd3, 1'b0, 4'd3, 1'b0, acc);
        checkOutput("bp_acc3_refused", acc, 1'b0);
        checkOutput("bp_in_ready", in_ready, 1'b0);
        repeat (3) applyStimulus(1'b1, 32'd30, 32'd3, 1'b0, 4'd3, 1'b0, acc);
        for (int i = 0; i < 5 && !acc; i++)
            applyStimulus(1'b1, 32'd30, 32'd3, 1'b0, 4'd3, 1'b1, acc);
        checkOutput("bp_acc3_late", acc, 1'b1);
        drain("drain_bp");

        $display("[TB] reset while full");
        applyStimulus(1'b1, 32'd1, 32'd1, 1'b0, 4'd8, 1'b0, acc);
        applyStimulus(1'b1, 32'd2, 32'd2, 1'b0, 4'd9, 1'b0, acc);
        idle(1'b0);
        checkOutput("full_in_ready", in_ready, 1'b0);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        checkOutput("midrst_out_valid", out_valid, 1'b0);
        checkOutput("midrst_sum", sum, 32'd0);
        checkOutput("midrst_cout", cout, 1'b0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("postrst_in_ready", in_ready, 1'b1);
        checkOutput("postrst_out_valid", out_valid, 1'b0);
        applyStimulus(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b1, 4'd4, 1'b1, acc);
        checkOutput("postrst_accept", acc, 1'b1);
        drain("drain_postrst");

        $display("[TB] random handshake");
        have = 1'b0;
        tag  = '0;
        a    = '0;
        b    = '0;
        cin  = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if (!have && $urandom_range(0, 1) == 1) begin
                a    = $urandom;
                b    = $urandom;
                cin  = 1'($urandom_range(0, 1));
                tag  = tag + 4'd1;
                have = 1'b1;
            end
            applyStimulus(have, a, b, cin, tag, 1'($urandom_range(0, 1)), acc);
            if (acc) have = 1'b0;
        end
        drain("drain_random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
